// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the IM port and
// fills the IF/ID register with stall, flush, halt and fault handling.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          IM_DEPTH  = 1024,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HLT_OP    = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_IF,
  input  logic        flush,
  input  logic [15:0] br_tgt,
  input  logic [15:0] instr_IM,
  output logic [15:0] addr,
  output logic        rd_en,
  output logic [15:0] instr_ID,
  output logic [15:0] pc_ID,
  output logic        valid_ID,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [16:0] DEPTH = 17'(IM_DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc;
  logic        in_range;
  logic        is_hlt;
  logic        running;

  assign in_range = ({1'b0, pc} < DEPTH);
  assign is_hlt   = (instr_IM[15:12] == HLT_OP);
  assign running  = (state == RUN);

  assign addr   = pc;
  assign rd_en  = rst_n & running & in_range;
  assign halted = (state == HALT);
  assign fault  = (state == FAULT);

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a redirect always resumes fetching.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (!in_range) begin
            state_nxt = FAULT;
          end else if (!stall_IF && is_hlt) begin
            state_nxt = HALT;
          end
        end
        HALT:    state_nxt = HALT;
        FAULT:   state_nxt = FAULT;
        default: state_nxt = RUN;
      endcase
    end
  end

  // PC and IF/ID register; a bubble is injected whenever not fetching.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      instr_ID <= NOP_INSTR;
      pc_ID    <= 16'h0000;
      valid_ID <= 1'b0;
    end else if (flush) begin
      pc       <= br_tgt;
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (!running || !in_range) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (!stall_IF) begin
      pc       <= pc + 16'd1;
      instr_ID <= instr_IM;
      pc_ID    <= pc + 16'd1;
      valid_ID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural IM on negedge plus a
// scoreboard of expected IF/ID and control outputs per cycle.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_IF;
  logic        flush;
  logic [15:0] br_tgt;
  logic [15:0] instr_IM;
  logic [15:0] addr;
  logic        rd_en;
  logic [15:0] instr_ID;
  logic [15:0] pc_ID;
  logic        valid_ID;
  logic        halted;
  logic        fault;

  logic [15:0] mem [0:1023];

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcid;
    logic        valid;
    logic        rd;
    logic        hlt;
    logic        flt;
  } exp_t;

  exp_t sb[$];

  fetch_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall_IF (stall_IF),
    .flush    (flush),
    .br_tgt   (br_tgt),
    .instr_IM (instr_IM),
    .addr     (addr),
    .rd_en    (rd_en),
    .instr_ID (instr_ID),
    .pc_ID    (pc_ID),
    .valid_ID (valid_ID),
    .halted   (halted),
    .fault    (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: reads on the falling edge.
  always @(negedge clk) begin
    if (rd_en) instr_IM <= mem[addr[9:0]];
  end

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic        r,
    input logic        s,
    input logic        f,
    input logic [15:0] t,
    input logic [15:0] ea,
    input logic [15:0] ei,
    input logic [15:0] ep,
    input logic        ev,
    input logic        er,
    input logic        eh,
    input logic        ef
  );
    exp_t e;
    rst_n    = r;
    stall_IF = s;
    flush    = f;
    br_tgt   = t;
    e = '{tag, ea, ei, ep, ev, er, eh, ef};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".addr"},   addr,             e.addr);
    chk({e.tag, ".instr"},  instr_ID,         e.instr);
    chk({e.tag, ".pc_ID"},  pc_ID,            e.pcid);
    chk({e.tag, ".valid"},  {15'd0, valid_ID}, {15'd0, e.valid});
    chk({e.tag, ".rd_en"},  {15'd0, rd_en},   {15'd0, e.rd});
    chk({e.tag, ".halted"}, {15'd0, halted},  {15'd0, e.hlt});
    chk({e.tag, ".fault"},  {15'd0, fault},   {15'd0, e.flt});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0]     = 16'h1111;
    mem[1]     = 16'h2222;
    mem[2]     = 16'h3333;
    mem[3]     = 16'hF000;
    mem[5]     = 16'h6666;
    mem[16]    = 16'h5A5A;
    mem[1023]  = 16'h7777;
    instr_IM = 16'h0000;

    //    tag      r  s  f  tgt       addr      instr     pc_ID    v  rd h  f
    step("rst0",  0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step("rst1",  0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step("run1",  1, 0, 0, 16'h0000, 16'h0001, 16'h1111, 16'h0001, 1, 1, 0, 0);
    step("run2",  1, 0, 0, 16'h0000, 16'h0002, 16'h2222, 16'h0002, 1, 1, 0, 0);
    step("stl1",  1, 1, 0, 16'h0000, 16'h0002, 16'h2222, 16'h0002, 1, 1, 0, 0);
    step("stl2",  1, 1, 0, 16'h0000, 16'h0002, 16'h2222, 16'h0002, 1, 1, 0, 0);
    step("run3",  1, 0, 0, 16'h0000, 16'h0003, 16'h3333, 16'h0003, 1, 1, 0, 0);
    step("hlt",   1, 0, 0, 16'h0000, 16'h0004, 16'hF000, 16'h0004, 1, 0, 1, 0);
    step("hlt2",  1, 0, 0, 16'h0000, 16'h0004, 16'h0000, 16'h0004, 0, 0, 1, 0);
    step("hflu",  1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 0, 1, 0, 0);
    step("res0",  1, 0, 0, 16'h0000, 16'h0001, 16'h1111, 16'h0001, 1, 1, 0, 0);
    step("sflu",  1, 1, 1, 16'h0010, 16'h0010, 16'h0000, 16'h0001, 0, 1, 0, 0);
    step("tgt",   1, 0, 0, 16'h0000, 16'h0011, 16'h5A5A, 16'h0011, 1, 1, 0, 0);
    step("oor",   1, 0, 1, 16'h0400, 16'h0400, 16'h0000, 16'h0011, 0, 0, 0, 0);
    step("flt1",  1, 0, 0, 16'h0000, 16'h0400, 16'h0000, 16'h0011, 0, 0, 0, 1);
    step("flt2",  1, 1, 0, 16'h0000, 16'h0400, 16'h0000, 16'h0011, 0, 0, 0, 1);
    step("fflu",  1, 0, 1, 16'h0005, 16'h0005, 16'h0000, 16'h0011, 0, 1, 0, 0);
    step("run5",  1, 0, 0, 16'h0000, 16'h0006, 16'h6666, 16'h0006, 1, 1, 0, 0);
    step("last",  1, 0, 1, 16'h03FF, 16'h03FF, 16'h0000, 16'h0006, 0, 1, 0, 0);
    step("edge",  1, 0, 0, 16'h0000, 16'h0400, 16'h7777, 16'h0400, 1, 0, 0, 0);
    step("flt3",  1, 0, 0, 16'h0000, 16'h0400, 16'h0000, 16'h0400, 0, 0, 0, 1);
    step("rstf",  0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step("post1", 1, 0, 0, 16'h0000, 16'h0001, 16'h1111, 16'h0001, 1, 1, 0, 0);
    step("to3",   1, 0, 1, 16'h0003, 16'h0003, 16'h0000, 16'h0001, 0, 1, 0, 0);
    step("hlt3",  1, 0, 0, 16'h0000, 16'h0004, 16'hF000, 16'h0004, 1, 0, 1, 0);
    step("rsth",  0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0);
    step("post2", 1, 0, 0, 16'h0000, 16'h0001, 16'h1111, 16'h0001, 1, 1, 0, 0);
    step("post3", 1, 0, 0, 16'h0000, 16'h0002, 16'h2222, 16'h0002, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
